// File: rtl/async_fifo_pkg.sv
// Shared constants and helpers for consumers of the async FIFO read port.
// Skid depth, occupancy width and the read-issue threshold live here so all readers agree.
package async_fifo_pkg;

  localparam int SKID_DEPTH = 2;
  localparam int OCC_W      = 2;

  typedef logic [OCC_W-1:0] occ_t;
  typedef logic [OCC_W:0]   commit_t;

  // A read may be issued only while committed words stay below the skid depth.
  localparam commit_t ISSUE_LIMIT = commit_t'(SKID_DEPTH);

  // Words held or owed to the skid buffer after this cycle's pop.
  function automatic commit_t committed_words(input occ_t occ, input logic inflight,
                                              input logic pop);
    return commit_t'(occ) + commit_t'(inflight) - commit_t'(pop);
  endfunction

endpackage

// File: rtl/async_fifo_skid2.sv
// Two-entry register skid buffer: entry 0 is the head, entry 1 the overflow slot.
// Handles push-only, pop-only, and simultaneous push/pop at any occupancy.
module async_fifo_skid2
  import async_fifo_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] head_data,
  output occ_t             occ
);

  logic [width-1:0] ent0_q, ent0_d;
  logic [width-1:0] ent1_q, ent1_d;
  occ_t             occ_q, occ_d;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q + occ_t'(push) - occ_t'(pop);
    if (pop) ent0_d = ent1_q;
    // The write slot is the occupancy left after the pop has shifted the buffer.
    if (push) begin
      if (occ_q == occ_t'(pop)) ent0_d = push_data;
      else                      ent1_d = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  always_ff @(posedge clk) begin
    ent0_q <= ent0_d;
    ent1_q <= ent1_d;
  end

  assign head_data = ent0_q;
  assign occ       = occ_q;

endmodule

// File: rtl/async_fifo_rd_adapter.sv
// Read-side drain engine: turns the FIFO read port (1-cycle latency) into a
// valid/ready stream with burst framing and a running beat count.
module async_fifo_rd_adapter
  import async_fifo_pkg::*;
#(
  parameter int width     = 8,
  parameter int burst_len = 4,
  parameter int cnt_w     = 16
) (
  input  logic             r_clk,
  input  logic             rst_r,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [width-1:0] fifo_r_data,
  output logic             fifo_r_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [width-1:0] m_data,
  output logic             m_last,
  output logic [cnt_w-1:0] beat_cnt
);

  localparam int BIDX_W = (burst_len > 1) ? $clog2(burst_len) : 1;
  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(burst_len - 1);

  occ_t              occ;
  logic [width-1:0]  head_data;
  logic              pop;
  commit_t           committed;
  logic              inflight_q, inflight_d;
  logic [BIDX_W-1:0] burst_idx_q, burst_idx_d;
  logic [cnt_w-1:0]  beat_cnt_q, beat_cnt_d;

  assign pop = m_valid && m_ready;

  always_comb begin
    committed  = committed_words(occ, inflight_q, pop);
    fifo_r_en  = !rst_r && en && !fifo_empty && (committed < ISSUE_LIMIT);
    inflight_d = fifo_r_en;
    burst_idx_d = burst_idx_q;
    beat_cnt_d  = beat_cnt_q;
    if (pop) begin
      burst_idx_d = (burst_idx_q == LAST_IDX) ? '0 : burst_idx_q + BIDX_W'(1);
      beat_cnt_d  = beat_cnt_q + cnt_w'(1);
    end
  end

  // Stage boundary: read issue -> data returns next cycle and lands in the skid buffer.
  always_ff @(posedge r_clk) begin
    if (rst_r) begin
      inflight_q  <= 1'b0;
      burst_idx_q <= '0;
      beat_cnt_q  <= '0;
    end else begin
      inflight_q  <= inflight_d;
      burst_idx_q <= burst_idx_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  async_fifo_skid2 #(.width(width)) u_skid (
    .clk       (r_clk),
    .rst       (rst_r),
    .push      (inflight_q),
    .push_data (fifo_r_data),
    .pop       (pop),
    .head_data (head_data),
    .occ       (occ)
  );

  // Data registers carry no reset, so the head is masked whenever the buffer is empty.
  assign m_valid  = (occ != '0);
  assign m_data   = m_valid ? head_data : '0;
  assign m_last   = m_valid && (burst_idx_q == LAST_IDX);
  assign beat_cnt = beat_cnt_q;

endmodule
